mem_sort_engine: RTL and testbench

// - Hardware bubble-sort accelerator; replaces the software bubble-sort loop run on the pipelined MIPS32 core.
// - Sorts LEN words in place in data memory, starting at word address BASE, through a single-port word memory interface.
// - Generalised over data width, address width, length range and signedness. Adds a runtime ascending/descending mode,

---
 rtl/sort_pkg.sv | 33 +++
 rtl/sort_cmp.sv | 30 +++
 rtl/mem_sort_engine.sv | 185 ++++++++++++++++++
 tb/tb_mem_sort_engine.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared state encoding, sort-direction constants and the swap decision used by
// the bubble-sort engine.
package sort_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD0,
        S_LOAD1,
        S_CMP,
        S_WR0,
        S_WR1,
        S_NEXT,
        S_DONE
    } sort_state_e;

    localparam logic MODE_ASC  = 1'b0;
    localparam logic MODE_DESC = 1'b1;

    // Operands arrive already sign- or zero-extended to CMP_W bits, so a single
    // signed compare serves both signedness choices for any DW up to 64.
    localparam int CMP_W = 65;

    // Swaps only on strict inequality, which keeps equal elements in order.
    function automatic logic swap_needed(input logic signed [CMP_W-1:0] cur,
                                         input logic signed [CMP_W-1:0] nxt,
                                         input logic                    desc);
        if (desc == MODE_DESC) begin
            return nxt > cur;
        end
        return nxt < cur;
    endfunction

endpackage

// File: rtl/sort_cmp.sv
// Combinational swap decision for one adjacent pair: a is the element already
// held (lower address), b is the element just read (higher address).
module sort_cmp
    import sort_pkg::*;
#(
    parameter int DW     = 32,
    parameter int SIGNED = 0
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          desc,
    output logic          swap
);

    localparam int EXT = CMP_W - DW;

    logic                    ext_a;
    logic                    ext_b;
    logic signed [CMP_W-1:0] a_ext;
    logic signed [CMP_W-1:0] b_ext;

    always_comb begin
        ext_a = (SIGNED != 0) ? a[DW-1] : 1'b0;
        ext_b = (SIGNED != 0) ? b[DW-1] : 1'b0;
        a_ext = {{EXT{ext_a}}, a};
        b_ext = {{EXT{ext_b}}, b};
        swap  = swap_needed(a_ext, b_ext, desc);
    end

endmodule

// File: rtl/mem_sort_engine.sv
// In-place bubble-sort accelerator over a single-port word memory, with runtime
// direction, early exit on a swap-free pass, and swap/pass statistics.
module mem_sort_engine
    import sort_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 10,
    parameter int LW     = 6,
    parameter int SIGNED = 0
) (
    input  logic            clk1,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   base,
    input  logic [LW-1:0]   len,
    input  logic            desc,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_rd_en,
    input  logic [DW-1:0]   mem_rdata,
    output logic            mem_wr_en,
    output logic [DW-1:0]   mem_wdata,
    output logic            busy,
    output logic            done,
    output logic [2*LW-1:0] swap_cnt,
    output logic [LW-1:0]   pass_cnt
);

    sort_state_e     state_q, state_d;
    logic [AW-1:0]   base_q, base_d;
    logic [LW-1:0]   len_q, len_d;
    logic            desc_q, desc_d;
    logic [LW-1:0]   j_q, j_d;
    logic [LW-1:0]   p_q, p_d;
    logic            swapped_q, swapped_d;
    logic [DW-1:0]   cur_q, cur_d;
    logic [DW-1:0]   nxt_q, nxt_d;
    logic [2*LW-1:0] swap_cnt_q, swap_cnt_d;
    logic [LW-1:0]   pass_cnt_q, pass_cnt_d;

    logic [LW-1:0]   lim;
    logic [LW-1:0]   j_inc;
    logic [AW-1:0]   addr_j;
    logic [AW-1:0]   addr_j1;
    logic            swap_hit;

    sort_cmp #(
        .DW     (DW),
        .SIGNED (SIGNED)
    ) u_cmp (
        .a    (cur_q),
        .b    (mem_rdata),
        .desc (desc_q),
        .swap (swap_hit)
    );

    // Each pass shortens by one because the largest remaining element settles at the end.
    assign lim     = len_q - LW'(1) - p_q;
    assign j_inc   = j_q + LW'(1);
    assign addr_j  = base_q + AW'(j_q);
    assign addr_j1 = addr_j + AW'(1);

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            desc_q     <= MODE_ASC;
            j_q        <= '0;
            p_q        <= '0;
            swapped_q  <= 1'b0;
            cur_q      <= '0;
            nxt_q      <= '0;
            swap_cnt_q <= '0;
            pass_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            desc_q     <= desc_d;
            j_q        <= j_d;
            p_q        <= p_d;
            swapped_q  <= swapped_d;
            cur_q      <= cur_d;
            nxt_q      <= nxt_d;
            swap_cnt_q <= swap_cnt_d;
            pass_cnt_q <= pass_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        desc_d     = desc_q;
        j_d        = j_q;
        p_d        = p_q;
        swapped_d  = swapped_q;
        cur_d      = cur_q;
        nxt_d      = nxt_q;
        swap_cnt_d = swap_cnt_q;
        pass_cnt_d = pass_cnt_q;
        mem_addr   = '0;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        mem_wdata  = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d     = base;
                    len_d      = len;
                    desc_d     = desc;
                    swap_cnt_d = '0;
                    pass_cnt_d = '0;
                    p_d        = '0;
                    j_d        = '0;
                    swapped_d  = 1'b0;
                    state_d    = (len[LW-1:1] == '0) ? S_DONE : S_LOAD0;
                end
            end
            S_LOAD0: begin
                mem_rd_en = 1'b1;
                mem_addr  = base_q;
                state_d   = S_LOAD1;
            end
            S_LOAD1: begin
                mem_rd_en = 1'b1;
                mem_addr  = addr_j1;
                if (j_q == '0) begin
                    cur_d = mem_rdata;
                end
                state_d = S_CMP;
            end
            S_CMP: begin
                nxt_d = mem_rdata;
                if (swap_hit) begin
                    swapped_d  = 1'b1;
                    swap_cnt_d = (swap_cnt_q == '1) ? swap_cnt_q : swap_cnt_q + 1'b1;
                    state_d    = S_WR0;
                end else begin
                    cur_d   = mem_rdata;
                    j_d     = j_inc;
                    state_d = (j_inc == lim) ? S_NEXT : S_LOAD1;
                end
            end
            S_WR0: begin
                mem_wr_en = 1'b1;
                mem_addr  = addr_j;
                mem_wdata = nxt_q;
                state_d   = S_WR1;
            end
            S_WR1: begin
                // cur keeps the larger (or smaller) element, which bubbles on without a re-read.
                mem_wr_en = 1'b1;
                mem_addr  = addr_j1;
                mem_wdata = cur_q;
                j_d       = j_inc;
                state_d   = (j_inc == lim) ? S_NEXT : S_LOAD1;
            end
            S_NEXT: begin
                pass_cnt_d = (pass_cnt_q == '1) ? pass_cnt_q : pass_cnt_q + 1'b1;
                if (!swapped_q || lim == LW'(1)) begin
                    state_d = S_DONE;
                end else begin
                    p_d       = p_q + 1'b1;
                    j_d       = '0;
                    swapped_d = 1'b0;
                    state_d   = S_LOAD0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done     = (state_q == S_DONE);
    assign swap_cnt = swap_cnt_q;
    assign pass_cnt = pass_cnt_q;

endmodule

// File: tb/tb_mem_sort_engine.sv
// Directed, table-driven bench for mem_sort_engine: an unsigned and a signed
// instance, each backed by its own word memory model with one-cycle read latency.
module tb_mem_sort_engine;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int LW = 6;
    localparam logic [DW-1:0] SENTINEL = 32'hDEAD_BEEF;

    typedef struct {
        logic [AW-1:0]        base;
        int                   n;
        logic                 d;
        logic                 use_s;
        logic [19:0][DW-1:0]  din;
        logic [19:0][DW-1:0]  dexp;
        int                   swaps;
        int                   passes;
        int                   lat;
    } vec_t;

    logic            clk1 = 1'b0;
    logic            rst = 1'b1;
    logic            start_u = 1'b0;
    logic            start_s = 1'b0;
    logic [AW-1:0]   base = '0;
    logic [LW-1:0]   len = '0;
    logic            desc = 1'b0;

    logic [AW-1:0]   mem_addr_u, mem_addr_s;
    logic            mem_rd_en_u, mem_rd_en_s, mem_wr_en_u, mem_wr_en_s;
    logic [DW-1:0]   mem_rdata_u, mem_rdata_s, mem_wdata_u, mem_wdata_s;
    logic            busy_u, busy_s, done_u, done_s;
    logic [2*LW-1:0] swap_cnt_u, swap_cnt_s;
    logic [LW-1:0]   pass_cnt_u, pass_cnt_s;

    logic [DW-1:0]   mem_u [1024];
    logic [DW-1:0]   mem_s [1024];
    logic            tb_we = 1'b0;
    logic [AW-1:0]   tb_addr = '0;
    logic [DW-1:0]   tb_data = '0;

    int rd_total_u = 0, wr_total_u = 0, rd_total_s = 0, wr_total_s = 0;
    int strobe_err = 0;
    int n_cmp = 0, n_fail = 0;
    vec_t vecs[10];

    always #5 clk1 = ~clk1;

    mem_sort_engine #(.DW(DW), .AW(AW), .LW(LW), .SIGNED(0)) dut_u (
        .clk1(clk1), .rst(rst), .start(start_u), .base(base), .len(len), .desc(desc),
        .mem_addr(mem_addr_u), .mem_rd_en(mem_rd_en_u), .mem_rdata(mem_rdata_u),
        .mem_wr_en(mem_wr_en_u), .mem_wdata(mem_wdata_u), .busy(busy_u), .done(done_u),
        .swap_cnt(swap_cnt_u), .pass_cnt(pass_cnt_u)
    );

    mem_sort_engine #(.DW(DW), .AW(AW), .LW(LW), .SIGNED(1)) dut_s (
        .clk1(clk1), .rst(rst), .start(start_s), .base(base), .len(len), .desc(desc),
        .mem_addr(mem_addr_s), .mem_rd_en(mem_rd_en_s), .mem_rdata(mem_rdata_s),
        .mem_wr_en(mem_wr_en_s), .mem_wdata(mem_wdata_s), .busy(busy_s), .done(done_s),
        .swap_cnt(swap_cnt_s), .pass_cnt(pass_cnt_s)
    );

    // Memory models: the bench preload port has priority, reads return data one cycle later,
    // and any cycle with two strobes or a non-zero idle address/data is counted as an error.
    always @(posedge clk1) begin
        if (tb_we) begin
            mem_u[tb_addr] <= tb_data;
            mem_s[tb_addr] <= tb_data;
        end else begin
            if (mem_wr_en_u) mem_u[mem_addr_u] <= mem_wdata_u;
            if (mem_wr_en_s) mem_s[mem_addr_s] <= mem_wdata_s;
        end
        if (mem_rd_en_u) mem_rdata_u <= mem_u[mem_addr_u];
        if (mem_rd_en_s) mem_rdata_s <= mem_s[mem_addr_s];
        if (mem_rd_en_u) rd_total_u <= rd_total_u + 1;
        if (mem_wr_en_u) wr_total_u <= wr_total_u + 1;
        if (mem_rd_en_s) rd_total_s <= rd_total_s + 1;
        if (mem_wr_en_s) wr_total_s <= wr_total_s + 1;
        if ((mem_rd_en_u && mem_wr_en_u) || (mem_rd_en_s && mem_wr_en_s) ||
            (!mem_rd_en_u && !mem_wr_en_u && (mem_addr_u != '0 || mem_wdata_u != '0)) ||
            (!mem_rd_en_s && !mem_wr_en_s && (mem_addr_s != '0 || mem_wdata_s != '0)))
            strobe_err <= strobe_err + 1;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] b, input int n, input logic [19:0][DW-1:0] d);
        @(negedge clk1);
        tb_we = 1'b1;
        for (int i = 0; i < n; i++) begin
            tb_addr = b + AW'(i);
            tb_data = d[i];
            @(negedge clk1);
        end
        tb_addr = b + AW'(n);
        tb_data = SENTINEL;
        @(negedge clk1);
        tb_we = 1'b0;
    endtask

    // Pulses start for one cycle, then counts edges from the accepting edge to the end of DONE.
    task automatic applyStimulus(input logic sel_s, input logic [AW-1:0] b, input int n,
                                 input logic d, output int lat);
        int k;
        @(negedge clk1);
        base = b;
        len  = LW'(n);
        desc = d;
        if (sel_s) start_s = 1'b1; else start_u = 1'b1;
        @(negedge clk1);
        start_u = 1'b0;
        start_s = 1'b0;
        base    = '0;
        len     = '0;
        desc    = 1'b0;
        checkOutput("busyAfterStart", sel_s ? busy_s : busy_u, (n >= 2) ? 1 : 0);
        k = 0;
        while (!(sel_s ? done_s : done_u) && k < 5000) begin
            @(negedge clk1);
            k++;
        end
        lat = k + 1;
        if (k >= 5000) begin
            checkOutput("doneTimeout", 0, 1);
        end else begin
            @(negedge clk1);
            checkOutput("donePulseWidth", sel_s ? done_s : done_u, 0);
            checkOutput("busyAfterDone", sel_s ? busy_s : busy_u, 0);
        end
    endtask

    task automatic runVector(input int idx, input vec_t v);
        int lat, rd0, wr0, exp_rd;
        logic [AW-1:0] a;
        preload(v.base, v.n, v.din);
        rd0 = v.use_s ? rd_total_s : rd_total_u;
        wr0 = v.use_s ? wr_total_s : wr_total_u;
        applyStimulus(v.use_s, v.base, v.n, v.d, lat);
        for (int i = 0; i < v.n; i++) begin
            a = v.base + AW'(i);
            checkOutput($sformatf("v%0d.mem[%0d]", idx, i), v.use_s ? mem_s[a] : mem_u[a], v.dexp[i]);
        end
        a = v.base + AW'(v.n);
        checkOutput($sformatf("v%0d.sentinel", idx), v.use_s ? mem_s[a] : mem_u[a], SENTINEL);
        checkOutput($sformatf("v%0d.swap_cnt", idx), v.use_s ? swap_cnt_s : swap_cnt_u, v.swaps);
        checkOutput($sformatf("v%0d.pass_cnt", idx), v.use_s ? pass_cnt_s : pass_cnt_u, v.passes);
        checkOutput($sformatf("v%0d.writes", idx), (v.use_s ? wr_total_s : wr_total_u) - wr0, 2 * v.swaps);
        exp_rd = 0;
        for (int p = 0; p < v.passes; p++) exp_rd += 1 + (v.n - 1 - p);
        checkOutput($sformatf("v%0d.reads", idx), (v.use_s ? rd_total_s : rd_total_u) - rd0, exp_rd);
        if (v.lat >= 0) checkOutput($sformatf("v%0d.latency", idx), lat, v.lat);
    endtask

    function automatic vec_t mk(input logic [AW-1:0] b, input int n, input logic d, input logic s,
                                input int sw, input int ps, input int lt);
        vec_t v;
        v.base = b; v.n = n; v.d = d; v.use_s = s;
        v.din = '0; v.dexp = '0;
        v.swaps = sw; v.passes = ps; v.lat = lt;
        return v;
    endfunction

    initial begin
        int lat, k;
        logic [19:0][DW-1:0] rev8;

        // Hand-computed vectors: reversed, sorted, descending, duplicates, signedness, wrap, short lengths.
        vecs[0] = mk(10'd100, 20, 1'b0, 1'b0, 190, 19, -1);
        vecs[1] = mk(10'd200, 20, 1'b0, 1'b0, 0, 1, 41);
        vecs[2] = mk(10'd300, 20, 1'b1, 1'b0, 190, 19, -1);
        for (int i = 0; i < 20; i++) begin
            vecs[0].din[i] = DW'(20 - i); vecs[0].dexp[i] = DW'(i + 1);
            vecs[1].din[i] = DW'(i + 1);  vecs[1].dexp[i] = DW'(i + 1);
            vecs[2].din[i] = DW'(i + 1);  vecs[2].dexp[i] = DW'(20 - i);
        end
        vecs[3] = mk(10'd400, 3, 1'b0, 1'b0, 2, 2, -1);
        vecs[3].din[0] = 5; vecs[3].din[1] = 5; vecs[3].din[2] = 3;
        vecs[3].dexp[0] = 3; vecs[3].dexp[1] = 5; vecs[3].dexp[2] = 5;
        vecs[4] = mk(10'd450, 4, 1'b0, 1'b0, 4, 3, -1);
        vecs[4].din[0] = 32'hFFFF_FFFD; vecs[4].din[1] = 5; vecs[4].din[2] = 0; vecs[4].din[3] = 32'hFFFF_FFF9;
        vecs[4].dexp[0] = 0; vecs[4].dexp[1] = 5; vecs[4].dexp[2] = 32'hFFFF_FFF9; vecs[4].dexp[3] = 32'hFFFF_FFFD;
        vecs[5] = mk(10'd450, 4, 1'b0, 1'b1, 4, 3, -1);
        vecs[5].din = vecs[4].din;
        vecs[5].dexp[0] = 32'hFFFF_FFF9; vecs[5].dexp[1] = 32'hFFFF_FFFD; vecs[5].dexp[2] = 0; vecs[5].dexp[3] = 5;
        vecs[6] = mk(10'd1020, 6, 1'b0, 1'b0, 15, 5, -1);
        for (int i = 0; i < 6; i++) begin
            vecs[6].din[i] = DW'(6 - i); vecs[6].dexp[i] = DW'(i + 1);
        end
        vecs[7] = mk(10'd500, 1, 1'b0, 1'b0, 0, 0, 1);
        vecs[7].din[0] = 77; vecs[7].dexp[0] = 77;
        vecs[8] = mk(10'd510, 0, 1'b0, 1'b0, 0, 0, 1);
        vecs[9] = mk(10'd520, 4, 1'b1, 1'b0, 3, 3, -1);
        vecs[9].din[0] = 2; vecs[9].din[1] = 9; vecs[9].din[2] = 2; vecs[9].din[3] = 7;
        vecs[9].dexp[0] = 9; vecs[9].dexp[1] = 7; vecs[9].dexp[2] = 2; vecs[9].dexp[3] = 2;
        rev8 = '0;
        for (int i = 0; i < 8; i++) rev8[i] = DW'(8 - i);

        $display("[TB] reset checks");
        repeat (3) @(negedge clk1);
        checkOutput("rst.busy", busy_u, 0);
        checkOutput("rst.done", done_u, 0);
        checkOutput("rst.rd_en", mem_rd_en_u, 0);
        checkOutput("rst.wr_en", mem_wr_en_u, 0);
        checkOutput("rst.addr", mem_addr_u, 0);
        checkOutput("rst.wdata", mem_wdata_u, 0);
        checkOutput("rst.swap_cnt", swap_cnt_u, 0);
        checkOutput("rst.pass_cnt", pass_cnt_u, 0);
        checkOutput("rst.busy_s", busy_s, 0);
        rst = 1'b0;

        $display("[TB] table vectors");
        for (int i = 0; i < 10; i++) runVector(i, vecs[i]);

        $display("[TB] start pulses mid-run and on the DONE cycle");
        preload(10'd700, 8, rev8);
        @(negedge clk1);
        base = 10'd700; len = 6'd8; desc = 1'b0; start_u = 1'b1;
        @(negedge clk1);
        start_u = 1'b0; base = '0; len = '0;
        repeat (15) @(negedge clk1);
        base = 10'd10; len = 6'd3; desc = 1'b1; start_u = 1'b1;
        @(negedge clk1);
        start_u = 1'b0; base = '0; len = '0; desc = 1'b0;
        k = 0;
        while (!done_u && k < 5000) begin
            @(negedge clk1);
            k++;
        end
        if (k >= 5000) checkOutput("midStart.timeout", 0, 1);
        base = '0; len = 6'd5; start_u = 1'b1;
        @(negedge clk1);
        start_u = 1'b0; len = '0;
        checkOutput("startOnDone.busy", busy_u, 0);
        checkOutput("startOnDone.done", done_u, 0);
        for (int i = 0; i < 8; i++) checkOutput($sformatf("midStart.mem[%0d]", i), mem_u[10'd700 + AW'(i)], i + 1);
        checkOutput("midStart.swap_cnt", swap_cnt_u, 28);
        checkOutput("midStart.pass_cnt", pass_cnt_u, 7);

        $display("[TB] reset during LOAD1 then fresh run");
        preload(10'd600, 8, rev8);
        @(negedge clk1);
        base = 10'd600; len = 6'd8; desc = 1'b0; start_u = 1'b1;
        @(negedge clk1);
        start_u = 1'b0; base = '0; len = '0;
        k = 0;
        while (!(mem_rd_en_u && mem_addr_u == 10'd603) && k < 200) begin
            @(negedge clk1);
            k++;
        end
        if (k >= 200) checkOutput("rstRun.reachLoad1", 0, 1);
        rst = 1'b1;
        @(negedge clk1);
        checkOutput("rstRun.busy", busy_u, 0);
        checkOutput("rstRun.rd_en", mem_rd_en_u, 0);
        checkOutput("rstRun.wr_en", mem_wr_en_u, 0);
        checkOutput("rstRun.swap_cnt", swap_cnt_u, 0);
        rst = 1'b0;
        // Two swaps landed before the reset, leaving 7,6,8,5,4,3,2,1 (26 inversions).
        applyStimulus(1'b0, 10'd600, 8, 1'b0, lat);
        for (int i = 0; i < 8; i++) checkOutput($sformatf("rstRun.mem[%0d]", i), mem_u[10'd600 + AW'(i)], i + 1);
        checkOutput("rstRun.swap_cnt2", swap_cnt_u, 26);
        checkOutput("rstRun.pass_cnt2", pass_cnt_u, 7);

        checkOutput("strobeViolations", strobe_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
